// File: rtl/parity_weight_sequencer.sv
// Time-multiplexed Hamming-weight and ISO7816 parity engine.
// One SLICE_WIDTH-bit popcount is accumulated per cycle across a latched character.
module parity_weight_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int SLICE_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   dataIn,
    input  logic                    parityIn,
    input  logic                    oddParity,
    input  logic                    dataInValid,
    output logic                    dataInReady,
    output logic [WEIGHT_WIDTH-1:0] weightOut,
    output logic                    parityOut,
    output logic                    parityError,
    output logic                    resultValid,
    input  logic                    resultReady,
    output logic                    busy
);

    localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0]   data_lat;
    logic                    parity_lat;
    logic                    odd_lat;
    logic [WEIGHT_WIDTH-1:0] acc;
    logic [IDX_W-1:0]        idx;

    logic [SLICE_WIDTH-1:0]  slice;
    logic [WEIGHT_WIDTH-1:0] slice_weight;
    logic [WEIGHT_WIDTH-1:0] sum;
    logic                    accept;
    logic                    last_slice;
    logic                    final_parity;

    function automatic logic [WEIGHT_WIDTH-1:0] popcount(input logic [SLICE_WIDTH-1:0] s);
        logic [WEIGHT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < SLICE_WIDTH; i++) begin
            n = n + WEIGHT_WIDTH'(s[i]);
        end
        return n;
    endfunction

    always_comb begin
        slice        = SLICE_WIDTH'(data_lat >> (int'(idx) * SLICE_WIDTH));
        slice_weight = popcount(slice);
        sum          = acc + slice_weight;
        last_slice   = (idx == LAST_IDX);
        accept       = (state == IDLE) && dataInValid;
        final_parity = sum[0] ^ odd_lat;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (dataInValid) state_next = SCAN;
            SCAN: if (last_slice)  state_next = DONE;
            DONE: if (resultReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Character latch: only the copy taken at accept is ever weighed.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_lat   <= dataIn;
            parity_lat <= parityIn;
            odd_lat    <= oddParity;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            idx         <= '0;
            dataInReady <= 1'b1;
            busy        <= 1'b0;
            resultValid <= 1'b0;
            weightOut   <= '0;
            parityOut   <= 1'b0;
            parityError <= 1'b0;
        end else begin
            state       <= state_next;
            dataInReady <= (state_next == IDLE);
            busy        <= (state_next != IDLE);
            resultValid <= (state_next == DONE);
            if (accept) begin
                acc <= '0;
                idx <= '0;
            end else if (state == SCAN) begin
                acc <= sum;
                idx <= last_slice ? '0 : idx + 1'b1;
                // Result registers load once per character and then hold until the next one.
                if (last_slice) begin
                    weightOut   <= sum;
                    parityOut   <= final_parity;
                    parityError <= parity_lat ^ final_parity;
                end
            end
        end
    end

endmodule

// File: tb/tb_parity_weight_sequencer.sv
// Scoreboard bench for parity_weight_sequencer: a 4-bit-slice and a full-width-slice instance.
module tb_parity_weight_sequencer;

    typedef struct {
        int w;
        int p;
        int e;
        int acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset_a, par_a, odd_a, vin_a, rdy_a, po_a, pe_a, rv_a, rr_a, busy_a;
    logic [7:0] data_a;
    logic [3:0] w_a;
    logic       reset_b, par_b, odd_b, vin_b, rdy_b, po_b, pe_b, rv_b, rr_b, busy_b;
    logic [7:0] data_b;
    logic [3:0] w_b;

    parity_weight_sequencer #(.DATA_WIDTH(8), .SLICE_WIDTH(4), .WEIGHT_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset_a), .dataIn(data_a), .parityIn(par_a), .oddParity(odd_a),
        .dataInValid(vin_a), .dataInReady(rdy_a), .weightOut(w_a), .parityOut(po_a),
        .parityError(pe_a), .resultValid(rv_a), .resultReady(rr_a), .busy(busy_a)
    );

    parity_weight_sequencer #(.DATA_WIDTH(8), .SLICE_WIDTH(8), .WEIGHT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset_b), .dataIn(data_b), .parityIn(par_b), .oddParity(odd_b),
        .dataInValid(vin_b), .dataInReady(rdy_b), .weightOut(w_b), .parityOut(po_b),
        .parityError(pe_b), .resultValid(rv_b), .resultReady(rr_b), .busy(busy_b)
    );

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic ready_of(input int inst);
        return (inst == 0) ? rdy_a : rdy_b;
    endfunction

    // Presents a character, waits for the accept edge and leaves dataInValid asserted.
    task automatic send(input int inst, input logic [7:0] d, input logic p, input logic o,
                        input int ew, input int ep, input int ee, input bit push, output int acc);
        int n;
        exp_t x;
        if (inst == 0) begin
            data_a = d; par_a = p; odd_a = o; vin_a = 1'b1;
        end else begin
            data_b = d; par_b = p; odd_b = o; vin_b = 1'b1;
        end
        n = 0;
        while (!ready_of(inst) && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            check("send_ready_timeout", 0, 1);
            acc = -1;
        end else begin
            acc = cyc + 1;
            x.w = ew; x.p = ep; x.e = ee; x.acc = acc;
            if (push) begin
                if (inst == 0) qa.push_back(x);
                else qb.push_back(x);
            end
        end
        tick();
    endtask

    logic prev_va = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (!reset_a) begin
            if (rv_a && !prev_va) begin
                if (qa.size() == 0) check("a_unexpected_valid", 1, 0);
                else check("a_latency", cyc, qa[0].acc + 2);
            end
            if (rv_a && rr_a && qa.size() > 0) begin
                x = qa.pop_front();
                check("a_weight", int'(w_a), x.w);
                check("a_parity", int'(po_a), x.p);
                check("a_error", int'(pe_a), x.e);
            end
        end
        prev_va <= rv_a && !reset_a;
    end

    logic prev_vb = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (!reset_b) begin
            if (rv_b && !prev_vb) begin
                if (qb.size() == 0) check("b_unexpected_valid", 1, 0);
                else check("b_latency", cyc, qb[0].acc + 1);
            end
            if (rv_b && rr_b && qb.size() > 0) begin
                x = qb.pop_front();
                check("b_weight", int'(w_b), x.w);
                check("b_parity", int'(po_b), x.p);
                check("b_error", int'(pe_b), x.e);
            end
        end
        prev_vb <= rv_b && !reset_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1, a2, a3, dummy;
        exp_t x;
        reset_a = 1'b1; reset_b = 1'b1;
        data_a = '0; par_a = 1'b0; odd_a = 1'b0; vin_a = 1'b0; rr_a = 1'b1;
        data_b = '0; par_b = 1'b0; odd_b = 1'b0; vin_b = 1'b0; rr_b = 1'b1;
        repeat (2) tick();
        reset_a = 1'b0; reset_b = 1'b0;

        // Reset / idle state
        check("rst_ready", int'(rdy_a), 1);
        check("rst_valid", int'(rv_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_weight", int'(w_a), 0);
        check("rst_parity", int'(po_a), 0);
        check("rst_error", int'(pe_a), 0);
        check("rst_b_ready", int'(rdy_b), 1);
        check("rst_b_valid", int'(rv_b), 0);
        tick();

        // 8'hA5, even convention
        send(0, 8'hA5, 1'b0, 1'b0, 4, 0, 0, 1'b1, dummy);
        vin_a = 1'b0;
        check("scan_busy", int'(busy_a), 1);
        check("scan_ready", int'(rdy_a), 0);
        repeat (3) tick();
        check("idle_ready", int'(rdy_a), 1);
        check("idle_busy", int'(busy_a), 0);
        check("idle_valid", int'(rv_a), 0);

        // 8'hFF odd, then 8'h07 even
        send(0, 8'hFF, 1'b0, 1'b1, 8, 1, 1, 1'b1, dummy);
        vin_a = 1'b0;
        repeat (3) tick();
        send(0, 8'h07, 1'b1, 1'b0, 3, 1, 0, 1'b1, dummy);
        vin_a = 1'b0;
        repeat (3) tick();

        // Backpressure with toggling inputs
        rr_a = 1'b0;
        send(0, 8'h01, 1'b1, 1'b0, 1, 1, 0, 1'b1, dummy);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_ready", int'(rdy_a), 0);
            if (rv_a) begin
                check("hold_weight", int'(w_a), 1);
                check("hold_parity", int'(po_a), 1);
                check("hold_error", int'(pe_a), 0);
            end
            data_a = ~data_a; par_a = ~par_a; odd_a = ~odd_a;
        end
        check("hold_valid", int'(rv_a), 1);
        data_a = 8'h0E; par_a = 1'b0; odd_a = 1'b1; rr_a = 1'b1;
        x.w = 3; x.p = 0; x.e = 0; x.acc = cyc + 2;
        qa.push_back(x);
        tick();
        check("release_ready", int'(rdy_a), 1);
        tick();
        vin_a = 1'b0;
        check("reaccept_busy", int'(busy_a), 1);
        repeat (3) tick();

        // Reset during SCAN
        send(0, 8'hF0, 1'b0, 1'b0, 4, 0, 0, 1'b0, dummy);
        reset_a = 1'b1;
        #1;
        check("abort_ready", int'(rdy_a), 1);
        check("abort_busy", int'(busy_a), 0);
        check("abort_valid", int'(rv_a), 0);
        check("abort_weight", int'(w_a), 0);
        check("abort_parity", int'(po_a), 0);
        check("abort_error", int'(pe_a), 0);
        vin_a = 1'b0;
        repeat (2) tick();
        reset_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_valid", int'(rv_a), 0);
        end

        // Full-width slice, back-to-back
        send(1, 8'h3C, 1'b0, 1'b0, 4, 0, 0, 1'b1, a1);
        send(1, 8'h81, 1'b1, 1'b1, 2, 1, 0, 1'b1, a2);
        send(1, 8'h7F, 1'b0, 1'b0, 7, 1, 1, 1'b1, a3);
        vin_b = 1'b0;
        check("b_period_1", a2 - a1, 3);
        check("b_period_2", a3 - a2, 3);
        repeat (4) tick();

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/parity_weight_sequencer.md
Name: parity_weight_sequencer

Overview:
Time-multiplexes one SLICE_WIDTH-bit population-count datapath over a DATA_WIDTH-bit character. It accumulates the total Hamming weight over DATA_WIDTH/SLICE_WIDTH cycles and derives the ISO7816 parity bit. It also reports a parity error against a received parity bit. It sits between the UART character buffers and the TX/RX framers, with valid/ready handshakes on both sides.

Parameters:
DATA_WIDTH, 8, character width in bits; must be an integer multiple of SLICE_WIDTH.
SLICE_WIDTH, 4, bits counted per cycle (popcount datapath width).
WEIGHT_WIDTH, 4, accumulator and weightOut width; must satisfy 2**WEIGHT_WIDTH > DATA_WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
dataIn  input  DATA_WIDTH  character to be weighed.
parityIn  input  1  received parity bit; sampled with dataIn.
oddParity  input  1  0 = even convention, 1 = odd convention; sampled with dataIn.
dataInValid  input  1  dataIn, parityIn and oddParity are valid.
dataInReady  output  1  block accepts a character.
weightOut  output  WEIGHT_WIDTH  Hamming weight of the accepted character.
parityOut  output  1  parity bit to transmit for the character.
parityError  output  1  parityIn differs from parityOut.
resultValid  output  1  weightOut, parityOut and parityError are valid.
resultReady  input  1  consumer accepts the result.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE, accumulator=0, slice index=0. All outputs are 0 except dataInReady=1.
- NSLICE = DATA_WIDTH/SLICE_WIDTH. The slice index counts 0..NSLICE-1. Slice k = dataIn bits [k*SLICE_WIDTH +: SLICE_WIDTH], taken from the latched copy.
- State IDLE:
  - dataInReady=1.
  - On the edge with dataInValid & dataInReady: latch dataIn, parityIn and oddParity; clear the accumulator; index=0; go to SCAN.
- State SCAN:
  - dataInReady=0, busy=1.
  - Each edge adds popcount(slice[index]) to the accumulator, zero-extended to WEIGHT_WIDTH; no overflow is possible under the parameter rule.
  - At the edge where index=NSLICE-1, the final slice is accumulated, index returns to 0, and the state moves to DONE.
  - Changes on dataIn, parityIn, oddParity or dataInValid during SCAN are ignored; only the latched copy is used.
- State DONE:
  - resultValid=1.
  - weightOut = accumulator.
  - parityOut = weightOut[0] XOR latched oddParity, so that the total of ones in data plus parity is even when oddParity=0 and odd when oddParity=1.
  - parityError = latched parityIn XOR parityOut.
  - All three outputs hold stable while resultReady=0 (unbounded backpressure).
  - On the edge with resultReady=1: go to IDLE, resultValid=0.
- Outputs are registered. weightOut, parityOut and parityError hold their last values in IDLE and SCAN; only resultValid qualifies them.
- Latency: resultValid rises NSLICE cycles after the accept edge. Throughput is at most one character per NSLICE+2 cycles.
- No overlap: dataInReady=0 in SCAN and DONE, including the DONE cycle where resultReady=1. A new character is accepted on the earliest edge after returning to IDLE.
- SLICE_WIDTH = DATA_WIDTH: NSLICE=1, and SCAN lasts exactly one cycle.
- Reset asserted in SCAN or DONE: immediate return to the reset values. The in-flight character is discarded and no resultValid is produced for it.
- resultReady asserted outside DONE has no effect.

Test Plan:
1. Reset then idle, defaults 8/4/4 → dataInReady=1, resultValid=0, busy=0, weightOut=0, parityOut=0, parityError=0.
2. Accept 8'hA5 with oddParity=0, parityIn=0, resultReady held 1 → resultValid 2 cycles after accept, weightOut=4, parityOut=0, parityError=0, then back in IDLE.
3. Accept 8'hFF with oddParity=1, parityIn=0 → weightOut=8, parityOut=1, parityError=1. Then accept 8'h07 with oddParity=0, parityIn=1 → weightOut=3, parityOut=1, parityError=0.
4. Accept 8'h01 with resultReady=0 for 10 cycles while dataIn toggles and dataInValid stays 1 → outputs stable at weight 1, dataInReady=0 throughout. Release resultReady → IDLE, and the next character is accepted one edge later.
5. Accept 8'hF0, then assert reset during the SCAN cycle → all outputs return to reset values within the reset-asserted cycle, and no resultValid pulse occurs.
6. Instance with SLICE_WIDTH=8: accept 8'h3C → resultValid 1 cycle after accept, weightOut=4; back-to-back characters accepted every 3 cycles.
